// File: rtl/clk_gen_cfg_seq_if.sv
// Clock-generator register port.
// master drives address/data/strobes; slave returns read data.
interface clk_gen_cfg_seq_if;
  logic [31:0] CG_ADDR;
  logic [31:0] CG_DI;
  logic        CG_WE;
  logic        CG_RE;
  logic [31:0] CG_DO;

  modport master (
    output CG_ADDR, CG_DI, CG_WE, CG_RE,
    input  CG_DO
  );

  modport slave (
    input  CG_ADDR, CG_DI, CG_WE, CG_RE,
    output CG_DO
  );
endinterface

// File: rtl/clk_gen_cfg_seq.sv
// Divider configuration sequencer: writes enabled shadow entries
// to the clock generator, reads each back and reports done/error.
module clk_gen_cfg_seq #(
  parameter int RD_WAIT    = 0,
  parameter int MIN_DIV    = 2,
  parameter int AUTO_START = 1
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        START,
  input  logic        CFG_WE,
  input  logic [2:0]  CFG_IDX,
  input  logic [15:0] CFG_DI,
  input  logic        CFG_MASK_WE,
  input  logic [4:0]  CFG_MASK,
  clk_gen_cfg_seq_if.master cg,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  ERR_CODE,
  output logic [2:0]  ERR_IDX
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WRITE, S_WAIT, S_READ, S_FIN
  } state_t;

  localparam logic [15:0] MIN_V  = 16'(MIN_DIV);
  localparam logic [2:0]  WAIT_V = 3'(RD_WAIT);

  state_t      st;
  logic [2:0]  idx;
  logic [2:0]  wcnt;
  logic [15:0] shadow [5];
  logic [4:0]  mask;
  logic        auto_pend;
  logic [15:0] cur;

  assign cur = shadow[idx];

  // 0x5 (2 MHz divider) is deliberately skipped
  function automatic logic [31:0] map_addr(input logic [2:0] i);
    case (i)
      3'd0:    map_addr = 32'h1;
      3'd1:    map_addr = 32'h2;
      3'd2:    map_addr = 32'h3;
      3'd3:    map_addr = 32'h4;
      default: map_addr = 32'h6;
    endcase
  endfunction

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      st         <= S_IDLE;
      idx        <= 3'd0;
      wcnt       <= 3'd0;
      shadow[0]  <= 16'd250;
      shadow[1]  <= 16'd2500;
      shadow[2]  <= 16'd25000;
      shadow[3]  <= 16'd5000;
      shadow[4]  <= 16'd1000;
      mask       <= 5'b11111;
      auto_pend  <= (AUTO_START != 0);
      cg.CG_ADDR <= 32'h0;
      cg.CG_DI   <= 32'h0;
      cg.CG_WE   <= 1'b0;
      cg.CG_RE   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      ERR_CODE   <= 2'b00;
      ERR_IDX    <= 3'd0;
    end else begin
      cg.CG_ADDR <= 32'h0;
      cg.CG_DI   <= 32'h0;
      cg.CG_WE   <= 1'b0;
      cg.CG_RE   <= 1'b0;
      DONE       <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (CFG_WE && CFG_IDX < 3'd5)
            shadow[CFG_IDX] <= CFG_DI;
          if (CFG_MASK_WE)
            mask <= CFG_MASK;
          if (START || auto_pend) begin
            auto_pend <= 1'b0;
            st        <= S_CHECK;
            idx       <= 3'd0;
            BUSY      <= 1'b1;
            ERR       <= 1'b0;
            ERR_CODE  <= 2'b00;
            ERR_IDX   <= 3'd0;
          end
        end
        S_CHECK: begin
          if (!mask[idx]) begin
            if (idx == 3'd4) begin
              st   <= S_FIN;
              DONE <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (cur < MIN_V) begin
            ERR      <= 1'b1;
            ERR_CODE <= 2'b01;
            ERR_IDX  <= idx;
            st       <= S_FIN;
            DONE     <= 1'b1;
          end else begin
            st         <= S_WRITE;
            cg.CG_WE   <= 1'b1;
            cg.CG_ADDR <= map_addr(idx);
            cg.CG_DI   <= {16'h0, cur};
          end
        end
        S_WRITE: begin
          if (RD_WAIT > 0) begin
            st   <= S_WAIT;
            wcnt <= WAIT_V - 3'd1;
          end else begin
            st         <= S_READ;
            cg.CG_RE   <= 1'b1;
            cg.CG_ADDR <= map_addr(idx);
          end
        end
        S_WAIT: begin
          if (wcnt == 3'd0) begin
            st         <= S_READ;
            cg.CG_RE   <= 1'b1;
            cg.CG_ADDR <= map_addr(idx);
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        S_READ: begin
          if (cg.CG_DO != {16'h0, cur}) begin
            ERR      <= 1'b1;
            ERR_CODE <= 2'b10;
            ERR_IDX  <= idx;
            st       <= S_FIN;
            DONE     <= 1'b1;
          end else if (idx == 3'd4) begin
            st   <= S_FIN;
            DONE <= 1'b1;
          end else begin
            idx <= idx + 3'd1;
            st  <= S_CHECK;
          end
        end
        S_FIN: begin
          st   <= S_IDLE;
          BUSY <= 1'b0;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gen_cfg_seq.sv
// Bench for clk_gen_cfg_seq: two instances (RD_WAIT=0 auto-start,
// RD_WAIT=2 manual) against a behavioural clock-generator model.
module tb_clk_gen_cfg_seq;

  logic OPB_CLK = 1'b0;
  logic OPB_RST = 1'b1;
  always #5 OPB_CLK = ~OPB_CLK;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int ccnt = 0;
  always @(posedge OPB_CLK) ccnt <= ccnt + 1;

  // instance 0
  logic        start, cfg_we, mask_we;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_di;
  logic [4:0]  cfg_mask;
  logic        busy, done, err;
  logic [1:0]  code;
  logic [2:0]  eidx;
  logic        bad = 1'b0;
  clk_gen_cfg_seq_if cg0();

  clk_gen_cfg_seq #(.RD_WAIT(0), .MIN_DIV(2), .AUTO_START(1)) dut0 (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .START(start),
    .CFG_WE(cfg_we), .CFG_IDX(cfg_idx), .CFG_DI(cfg_di),
    .CFG_MASK_WE(mask_we), .CFG_MASK(cfg_mask), .cg(cg0),
    .BUSY(busy), .DONE(done), .ERR(err),
    .ERR_CODE(code), .ERR_IDX(eidx)
  );

  // instance 2
  logic        start2, cfg_we2, mask_we2;
  logic [2:0]  cfg_idx2;
  logic [15:0] cfg_di2;
  logic [4:0]  cfg_mask2;
  logic        busy2, done2, err2;
  logic [1:0]  code2;
  logic [2:0]  eidx2;
  clk_gen_cfg_seq_if cg2();

  clk_gen_cfg_seq #(.RD_WAIT(2), .MIN_DIV(2), .AUTO_START(0)) dut2 (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .START(start2),
    .CFG_WE(cfg_we2), .CFG_IDX(cfg_idx2), .CFG_DI(cfg_di2),
    .CFG_MASK_WE(mask_we2), .CFG_MASK(cfg_mask2), .cg(cg2),
    .BUSY(busy2), .DONE(done2), .ERR(err2),
    .ERR_CODE(code2), .ERR_IDX(eidx2)
  );

  // clock-generator models
  logic [31:0] regs0 [8] = '{default: 32'h0};
  logic [31:0] regs2 [8] = '{default: 32'h0};
  logic [31:0] wa0[$], wd0[$], wa2[$], wd2[$];

  assign cg0.CG_DO = !cg0.CG_RE ? 32'h0 :
    (bad && cg0.CG_ADDR == 32'h4) ? 32'hFFFF :
    regs0[cg0.CG_ADDR[2:0]];
  assign cg2.CG_DO = cg2.CG_RE ? regs2[cg2.CG_ADDR[2:0]] : 32'h0;

  always @(posedge OPB_CLK) begin
    if (cg0.CG_WE) begin
      regs0[cg0.CG_ADDR[2:0]] <= cg0.CG_DI;
      wa0.push_back(cg0.CG_ADDR);
      wd0.push_back(cg0.CG_DI);
    end
    if (cg2.CG_WE) begin
      regs2[cg2.CG_ADDR[2:0]] <= cg2.CG_DI;
      wa2.push_back(cg2.CG_ADDR);
      wd2.push_back(cg2.CG_DI);
    end
  end

  always @(negedge OPB_CLK) begin
    if (cg0.CG_WE && cg0.CG_RE) viol++;
    if (cg2.CG_WE && cg2.CG_RE) viol++;
    if (!cg0.CG_WE && !cg0.CG_RE && (cg0.CG_ADDR != 0 || cg0.CG_DI != 0)) viol++;
    if (!cg2.CG_WE && !cg2.CG_RE && (cg2.CG_ADDR != 0 || cg2.CG_DI != 0)) viol++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // call #1 after the START-accept edge; cyc is the DONE cycle number
  task automatic wait_done(input bit sel, output int cyc,
                           output int bcnt, output bit ok);
    cyc = 1;
    bcnt = 0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sel ? busy2 : busy) bcnt++;
      if (sel ? done2 : done) begin
        ok = 1'b1;
        break;
      end
      @(posedge OPB_CLK); #1;
      cyc++;
    end
  endtask

  task automatic check_full(input string tag);
    logic [31:0] ea [5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h6};
    logic [31:0] ed [5] = '{32'd250, 32'd2500, 32'd25000, 32'd5000, 32'd1000};
    int cyc, bc;
    bit ok;
    wait_done(1'b0, cyc, bc, ok);
    chk({tag, "_done_seen"}, 32'(ok), 1);
    chk({tag, "_done_cyc"}, cyc, 16);
    chk({tag, "_busy_cycles"}, bc, 16);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_nwr"}, wa0.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < wa0.size()) begin
        chk($sformatf("%s_addr%0d", tag, k), wa0[k], ea[k]);
        chk($sformatf("%s_data%0d", tag, k), wd0[k], ed[k]);
      end
    @(posedge OPB_CLK); #1;
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] val;
    logic [4:0]  mask;
    logic        bad;
    int          n_wr;
    int          dcyc;
    logic        err;
    logic [1:0]  code;
    logic [2:0]  eidx;
    logic [31:0] la;
    logic [31:0] ld;
  } vec_t;

  vec_t vt [8];

  initial begin
    int cyc, bc, g, s0, dn;
    bit ok;

    vt[0] = '{3'd2, 16'd10000, 5'b10100, 1'b0, 2, 10, 1'b0, 2'd0, 3'd0, 32'h6, 32'd1000};
    vt[1] = '{3'd1, 16'd1,     5'b11111, 1'b0, 1, 5,  1'b1, 2'd1, 3'd1, 32'h1, 32'd250};
    vt[2] = '{3'd1, 16'd2500,  5'b11111, 1'b1, 4, 13, 1'b1, 2'd2, 3'd3, 32'h4, 32'd5000};
    vt[3] = '{3'd2, 16'd25000, 5'b00000, 1'b0, 0, 6,  1'b0, 2'd0, 3'd0, 32'h0, 32'd0};
    vt[4] = '{3'd0, 16'd2,     5'b00001, 1'b0, 1, 8,  1'b0, 2'd0, 3'd0, 32'h1, 32'd2};
    vt[5] = '{3'd4, 16'd1,     5'b01111, 1'b0, 4, 14, 1'b0, 2'd0, 3'd0, 32'h4, 32'd5000};
    vt[6] = '{3'd4, 16'd1000,  5'b11111, 1'b0, 5, 16, 1'b0, 2'd0, 3'd0, 32'h6, 32'd1000};
    vt[7] = '{3'd5, 16'd1,     5'b11111, 1'b0, 5, 16, 1'b0, 2'd0, 3'd0, 32'h6, 32'd1000};

    start = 0; cfg_we = 0; mask_we = 0; cfg_idx = 0; cfg_di = 0; cfg_mask = 0;
    start2 = 0; cfg_we2 = 0; mask_we2 = 0; cfg_idx2 = 0; cfg_di2 = 0; cfg_mask2 = 0;

    repeat (3) @(posedge OPB_CLK);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(cg0.CG_WE), 0);
    chk("rst_addr", cg0.CG_ADDR, 0);
    OPB_RST = 0;
    @(posedge OPB_CLK); #1;
    check_full("auto");

    foreach (vt[i]) begin
      cfg_we = 1; cfg_idx = vt[i].idx; cfg_di = vt[i].val;
      mask_we = 1; cfg_mask = vt[i].mask;
      @(posedge OPB_CLK); #1;
      cfg_we = 0; mask_we = 0;
      bad = vt[i].bad;
      wa0.delete(); wd0.delete();
      start = 1;
      @(posedge OPB_CLK); #1;
      start = 0;
      wait_done(1'b0, cyc, bc, ok);
      chk($sformatf("v%0d_done_seen", i), 32'(ok), 1);
      chk($sformatf("v%0d_done_cyc", i), cyc, vt[i].dcyc);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].err));
      chk($sformatf("v%0d_code", i), 32'(code), 32'(vt[i].code));
      chk($sformatf("v%0d_eidx", i), 32'(eidx), 32'(vt[i].eidx));
      chk($sformatf("v%0d_nwr", i), wa0.size(), vt[i].n_wr);
      if (wa0.size() > 0) begin
        chk($sformatf("v%0d_last_addr", i), wa0[wa0.size()-1], vt[i].la);
        chk($sformatf("v%0d_last_data", i), wd0[wd0.size()-1], vt[i].ld);
      end
      @(posedge OPB_CLK); #1;
      bad = 0;
    end

    // RD_WAIT=2 gaps, mid-sequence START/CFG writes ignored
    wa2.delete(); wd2.delete();
    start2 = 1;
    @(posedge OPB_CLK); #1;
    start2 = 0;
    s0 = ccnt;
    for (int e = 0; e < 5; e++) begin
      ok = 0;
      for (int k = 0; k < 20; k++) begin
        if (cg2.CG_WE) begin ok = 1; break; end
        @(posedge OPB_CLK); #1;
      end
      chk($sformatf("rw_we%0d_seen", e), 32'(ok), 1);
      if (e == 1) begin
        start2 = 1; cfg_we2 = 1; cfg_idx2 = 0; cfg_di2 = 999;
        mask_we2 = 1; cfg_mask2 = 0;
      end
      g = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge OPB_CLK); #1;
        start2 = 0; cfg_we2 = 0; mask_we2 = 0;
        g++;
        if (cg2.CG_RE) break;
      end
      chk($sformatf("rw_gap%0d", e), g, 3);
    end
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (done2) begin ok = 1; break; end
      @(posedge OPB_CLK); #1;
    end
    chk("rw_done_seen", 32'(ok), 1);
    chk("rw_done_cyc", ccnt - s0 + 1, 26);
    @(posedge OPB_CLK); #1;
    chk("rw_busy_after", 32'(busy2), 0);

    wa2.delete(); wd2.delete();
    start2 = 1;
    @(posedge OPB_CLK); #1;
    start2 = 0;
    wait_done(1'b1, cyc, bc, ok);
    chk("rw2_done_cyc", cyc, 26);
    chk("rw2_nwr", wa2.size(), 5);
    if (wa2.size() > 0) chk("rw2_data0", wd2[0], 250);
    @(posedge OPB_CLK); #1;

    // reset during READ of entry 2
    start = 1;
    @(posedge OPB_CLK); #1;
    start = 0;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      if (cg0.CG_RE && cg0.CG_ADDR == 32'h3) begin ok = 1; break; end
      @(posedge OPB_CLK); #1;
    end
    chk("mid_read_seen", 32'(ok), 1);
    OPB_RST = 1;
    #1;
    chk("mid_rst_re", 32'(cg0.CG_RE), 0);
    chk("mid_rst_addr", cg0.CG_ADDR, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge OPB_CLK); #1;
      if (done) dn++;
    end
    chk("mid_rst_no_done", dn, 0);
    wa0.delete(); wd0.delete();
    OPB_RST = 0;
    @(posedge OPB_CLK); #1;
    check_full("rerun");

    chk("protocol", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
